// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch state encoding, opcodes, widths.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned IDX_W   = 26;

  // Fetch handshake state: waiting on imem, or holding a valid instruction
  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_J     = 6'd2;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;

  // Primary opcode field of an instruction word
  function automatic logic [OP_W-1:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC select, jump > taken branch > sequential.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic [IDX_W-1:0]  i_instr_idx,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic              i_jump,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;

  // Branch offset: sign-extended 16-bit word offset, scaled to bytes
  assign w_br_off = {{(ADDR_W-18){i_instr_idx[15]}}, i_instr_idx[15:0], 2'b00};
  assign w_br_tgt = i_pc_plus4 + w_br_off;

  // Jump target keeps the upper region bits of pc+4 when the PC is wider than 28 bits
  generate
    if (ADDR_W > 28) begin : g_jtgt_wide
      assign w_j_tgt = {i_pc_plus4[ADDR_W-1:28], i_instr_idx, 2'b00};
    end else begin : g_jtgt_narrow
      assign w_j_tgt = {i_instr_idx, 2'b00};
    end
  endgenerate

  // Priority select of the next PC
  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_j_tgt;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_br_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and single-outstanding instruction fetch stage.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt counters.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [OP_W-1:0]    op_out,
  output logic               instr_valid,
  input  logic               stall_in,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  // Reset PC forced word-aligned so pc[1:0] stays 00
  localparam logic [ADDR_W-1:0] LP_RESET_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [ADDR_W-1:0]  w_pc_plus4;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_req;
  logic               w_valid;
  logic               w_consume;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  // Next-PC selection from decoder/ALU controls and the held instruction
  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_calc (
    .i_pc_plus4  (w_pc_plus4),
    .i_instr_idx (r_instr[IDX_W-1:0]),
    .i_branch    (branch),
    .i_zero      (zero),
    .i_jump      (jump),
    .o_next_pc   (w_next_pc)
  );

  // State, PC and instruction holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= LP_RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // Handshake next-state: capture on ready in FETCH, commit PC on consumption in VALID
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = VALID;
        end
      end
      VALID: begin
        w_valid = 1'b1;
        if (!stall_in) begin
          w_consume   = 1'b1;
          w_pc_nxt    = w_next_pc;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // Request is gated by rst_n so an in-flight fetch drops the moment reset asserts
  assign imem_req    = w_req & rst_n;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_out   = r_instr;
  assign op_out      = get_op(r_instr);
  assign instr_valid = w_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall_cyc;

  assign w_stall_cyc = ((r_state == VALID) && stall_in) ||
                       ((r_state == FETCH) && !imem_ready);

  // Consumed-instruction and stall-cycle counters, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_consume) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall_cyc) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  // Consumption only feeds the optional counters
  logic w_unused;
  assign w_unused = w_consume;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: handshake, next-PC selection, stall and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [5:0]  op_out;
  logic        instr_valid;
  logic        stall_in;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .op_out      (op_out),
    .instr_valid (instr_valid),
    .stall_in    (stall_in),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Single comparison point: count and report mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, landing on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Zero-wait fetch of one instruction at exp_pc, then consume it with the given controls
  task automatic run_instr(input string tag, input logic [31:0] exp_pc, input logic [31:0] ins,
                           input logic [5:0] exp_op, input logic br, input logic zr, input logic jp);
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, exp_pc);
    imem_ready = 1'b1;
    imem_rdata = ins;
    step();
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr_out, ins);
    check({tag, "_op"}, 32'(op_out), 32'(exp_op));
    check({tag, "_pc4"}, pc_plus4, exp_pc + 32'd4);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    branch     = br;
    zero       = zr;
    jump       = jp;
    step();
    branch = 1'b0;
    zero   = 1'b0;
    jump   = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall_in   = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);

    rst_n = 1'b1;
    #1;
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", imem_addr, 32'h0);

    // lw at 0, nop at 4
    run_instr("lw", 32'h0, 32'h8C08_0004, 6'd35, 1'b0, 1'b0, 1'b0);
    run_instr("nop4", 32'h4, 32'h0000_0000, 6'd0, 1'b0, 1'b0, 1'b0);

    // imem wait states at pc=8: request and address hold, nothing captured
    imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_valid", 32'(instr_valid), 32'd0);
      step();
    end
    check("wait_nocap", instr_out, 32'h0);

    // Ready edge captures j 0x40 at pc=8
    imem_ready = 1'b1;
    imem_rdata = 32'h0800_0040;
    step();
    check("j8_valid", 32'(instr_valid), 32'd1);
    check("j8_instr", instr_out, 32'h0800_0040);
    check("j8_op", 32'(op_out), 32'd2);

    // Stall 5 cycles in VALID; stray ready and jump must be ignored
    stall_in = 1'b1;
    jump     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_instr", instr_out, 32'h0800_0040);
      check("stall_pc", pc_out, 32'h8);
    end
    stall_in   = 1'b0;
    imem_ready = 1'b0;
    step();
    jump = 1'b0;
    check("resume_valid", 32'(instr_valid), 32'd0);

    // Branches around 0x100
    run_instr("beq_t", 32'h100, 32'h1000_FFFE, 6'd4, 1'b1, 1'b1, 1'b0);
    run_instr("beq_back", 32'h0FC, 32'h1000_0000, 6'd4, 1'b1, 1'b1, 1'b0);
    run_instr("beq_nt", 32'h100, 32'h1000_FFFE, 6'd4, 1'b1, 1'b0, 1'b0);
    run_instr("j40", 32'h104, 32'h0800_0010, 6'd2, 1'b0, 1'b0, 1'b1);

    // Reset mid-request at pc=0x40
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_addr", imem_addr, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_pc", pc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("post_rst_fcnt", fetch_cnt, 32'h0);
    check("post_rst_scnt", stall_cnt, 32'h0);
`endif

    // Walk across the 256MB region boundary, then jump with branch also set
    run_instr("jfar", 32'h0, 32'h0BFF_FFFF, 6'd2, 1'b0, 1'b0, 1'b1);
    run_instr("edge", 32'h0FFF_FFFC, 32'h0000_0000, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_instr("seq", 32'h1000_0000 + 32'(4 * i), 32'h0000_0000, 6'd0, 1'b0, 1'b0, 1'b0);
    end
    run_instr("jbr", 32'h1000_0010, 32'h0800_0040, 6'd2, 1'b1, 1'b1, 1'b1);
    run_instr("self", 32'h1000_0100, 32'h1000_FFFF, 6'd4, 1'b1, 1'b1, 1'b0);
    run_instr("zonly", 32'h1000_0100, 32'h1000_0005, 6'd4, 1'b0, 1'b1, 1'b0);
    check("final_addr", imem_addr, 32'h1000_0104);
    check("final_req", 32'(imem_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the opcode decoder/control block in the MIPS datapath.
- Owns the PC register and runs a one-outstanding-request handshake to instruction memory.
- Holds the fetched word and presents `op_out` (bits 31:26) to the decoder.
- Computes the next PC from the decoder's branch/jump outputs and the ALU zero flag, then commits it when downstream consumes the instruction.

Parameters:
- ADDR_W, 32, width of PC and imem address (≥28).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until imem_ready.
- imem_addr  out  ADDR_W  word-aligned fetch address, equal to pc_out.
- imem_ready  in  1  imem_rdata valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction.
- instr_out  out  32  held instruction word.
- op_out  out  6  instr_out[31:26], feeds decoder op.
- instr_valid  out  1  instr_out valid.
- stall_in  in  1  downstream hold; instruction not consumed while high.
- branch  in  1  decoder branch (beq).
- zero  in  1  ALU zero flag for current instruction.
- jump  in  1  decoder jump.
- pc_out  out  ADDR_W  PC of current fetch/held instruction.
- pc_plus4  out  ADDR_W  pc_out + 4, combinational.

Behaviour:
- Reset (async, rst_n low):
  - pc ← RESET_PC, state ← FETCH, instr_out ← 0, instr_valid ← 0.
  - imem_req is 0 while rst_n is low.
- State FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On an edge with imem_ready=1: instr_out ← imem_rdata, go VALID.
  - Otherwise remain; imem_addr must stay stable.
- State VALID:
  - imem_req=0, instr_valid=1.
  - Consumption is `instr_valid && !stall_in`. On that edge, pc ← next_pc and go FETCH.
  - If stall_in=1: hold pc, instr_out and state indefinitely.
- Minimum throughput is one instruction per 2 cycles with zero-wait imem.
- next_pc is combinational and sampled only on the consumption edge. Priority is jump > taken branch > sequential:
  - jump=1: {pc_plus4[ADDR_W-1:28], instr_out[25:0], 2'b00}.
  - branch=1 and zero=1: pc_plus4 + (sign_extend(instr_out[15:0]) << 2).
  - else: pc_plus4.
- Arithmetic is modulo 2^ADDR_W. pc 32'hFFFF_FFFC + 4 wraps to 0 without flagging.
- Negative offsets are sign-extended from bit 15; offset 16'hFFFF targets pc_plus4 − 4 = pc (self-loop).
- Both branch and jump asserted: jump wins. branch=1 with zero=0: sequential.
- branch, zero and jump are ignored outside the consumption edge.
- Reset mid-request: the outstanding request is abandoned and imem_req drops asynchronously. The first post-reset request is to RESET_PC.
- imem_ready while imem_req=0 is ignored.
- pc[1:0] is always 00 by construction.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - fetch_cnt (32): increments on each consumption edge.
  - stall_cnt (32): increments each cycle in VALID with stall_in=1, or in FETCH with imem_ready=0.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding constants FETCH=1'b0, VALID=1'b1;
  - opcode constants OP_RTYPE=6'd0, OP_J=6'd2, OP_BEQ=6'd4, OP_LW=6'd35, OP_SW=6'd43;
  - INSTR_W=32.
- One sub-module, next_pc_calc: combinational (pc_plus4, instr_out, branch, zero, jump) → next_pc.

Test Plan:
- Reset then zero-wait imem returning 32'h8C08_0004 (lw): imem_addr=0 in cycle 1; instr_valid=1 and op_out=35 in cycle 2. With stall_in=0, the next fetch is at 4.
- imem_ready held low for 3 cycles at pc=8: imem_req=1 and imem_addr=8 stable throughout. The instruction is captured only on the ready edge.
- At pc=0x100 with beq, offset 16'hFFFE, branch=1, zero=1: next imem_addr=0x0FC. Same case with zero=0: 0x104.
- At pc=0x1000_0010 with j target 26'h000_0040, jump=1 and branch=1 asserted together: next imem_addr=0x1000_0100.
- stall_in=1 for 5 cycles in VALID: instr_out, pc_out and instr_valid unchanged and imem_req=0. The fetch resumes the cycle after stall_in falls.
- rst_n pulsed low while imem_req=1 at pc=0x40: imem_req drops immediately. After release, imem_addr=RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.
